// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types for the MEM/WB boundary of the RV32I core.
//   wb_sel_t  : writeback source select. The execute and memory stages
//               carry it unchanged down to writeback.
//   mem_wb_t  : contents of the MEM/WB pipeline register.
//   RV_XLEN   : architectural datapath width that the register struct is
//               sized for.
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int RV_XLEN = 32;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_MEM  = 2'd1,
        WB_SEL_PC4  = 2'd2,
        WB_SEL_NONE = 2'd3
    } wb_sel_t;

    // retired marks a held instruction that has already written the
    // register file and been counted, so a stall does not repeat either.
    typedef struct packed {
        logic               valid;
        logic               reg_wr_en;
        logic [4:0]         rd;
        wb_sel_t            wb_sel;
        logic [RV_XLEN-1:0] alu_result;
        logic [RV_XLEN-1:0] load_data;
        logic [RV_XLEN-1:0] pc_plus4;
        logic               retired;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_mux.sv
// -----------------------------------------------------------------------------
// wb_mux
// Purely combinational 4:1 writeback source select.
// Ports:
//   sel         in   writeback source (wb_sel_t)
//   alu_result  in   ALU result
//   load_data   in   extended load data
//   pc_plus4    in   link value
//   data        out  selected writeback value (0 for WB_SEL_NONE)
// -----------------------------------------------------------------------------
module wb_mux
    import wb_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  wb_sel_t         sel,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] load_data,
    input  logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] data
);

    always_comb begin
        data = '0;
        unique case (sel)
            WB_SEL_ALU:  data = alu_result;
            WB_SEL_MEM:  data = load_data;
            WB_SEL_PC4:  data = pc_plus4;
            WB_SEL_NONE: data = '0;
            default:     data = '0;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// MEM/WB pipeline register and writeback stage. It captures the instruction
// leaving the memory stage and drives the register-file write port and the
// writeback-to-execute forwarding bus. It also keeps the retired-instruction
// counter. Stall holds the register. Flush replaces it with a bubble.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mem_*             instruction fields from the memory stage
//   wb_stall/flush    hazard unit controls (flush wins over stall)
//   rf_wr_en/addr/data register-file write port
//   fwd_valid/rd/data forwarding bus
//   instret           retired-instruction count (wraps silently)
// All outputs are driven from registered state only.
// -----------------------------------------------------------------------------
module mem_wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic             mem_reg_wr_en,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_wb_sel,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_load_data,
    input  logic [XLEN-1:0]  mem_pc_plus4,
    input  logic             wb_stall,
    input  logic             wb_flush,
    output logic             rf_wr_en,
    output logic [4:0]       rf_wr_addr,
    output logic [XLEN-1:0]  rf_wr_data,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] instret
);

    mem_wb_t          wb_p0;
    mem_wb_t          cap_p0;
    logic [CNT_W-1:0] instret_p0;
    logic [XLEN-1:0]  wb_data;
    logic             writes_rd;

    always_comb begin
        cap_p0            = '0;
        cap_p0.valid      = mem_valid;
        cap_p0.reg_wr_en  = mem_reg_wr_en;
        cap_p0.rd         = mem_rd;
        cap_p0.wb_sel     = wb_sel_t'(mem_wb_sel);
        cap_p0.alu_result = mem_alu_result;
        cap_p0.load_data  = mem_load_data;
        cap_p0.pc_plus4   = mem_pc_plus4;
        cap_p0.retired    = 1'b0;
    end

    // ---- MEM -> WB register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_p0      <= '0;
            instret_p0 <= '0;
        end else begin
            // The held instruction retires on the edge it leaves or becomes
            // retired, whatever flush/stall does to the register.
            if (wb_p0.valid && !wb_p0.retired)
                instret_p0 <= instret_p0 + CNT_W'(1);

            if (wb_flush) begin
                wb_p0.valid     <= 1'b0;
                wb_p0.reg_wr_en <= 1'b0;
                wb_p0.retired   <= 1'b0;
            end else if (wb_stall) begin
                wb_p0.retired <= wb_p0.valid;
            end else begin
                wb_p0 <= cap_p0;
            end
        end
    end

    // ---- WB combinational outputs ----
    wb_mux #(.XLEN(XLEN)) u_wb_mux (
        .sel        (wb_p0.wb_sel),
        .alu_result (wb_p0.alu_result),
        .load_data  (wb_p0.load_data),
        .pc_plus4   (wb_p0.pc_plus4),
        .data       (wb_data)
    );

    assign writes_rd  = wb_p0.valid && wb_p0.reg_wr_en && (wb_p0.rd != 5'd0);

    assign rf_wr_en   = writes_rd && !wb_p0.retired;
    assign rf_wr_addr = wb_p0.rd;
    assign rf_wr_data = wb_data;

    assign fwd_valid  = writes_rd;
    assign fwd_rd     = wb_p0.rd;
    assign fwd_data   = wb_data;

    assign instret    = instret_p0;

endmodule
